// File: rtl/axi_fifo_pkg.sv
// Shared constants and AR payload layout for the AXI read-address delay FIFO.
// The slot itself treats the payload as opaque; the field map serves the parent FIFO.
package axi_fifo_pkg;

  localparam int DATA_WIDTH = 71;
  localparam int CNT_WIDTH  = 32;

  localparam int ARTRUST_LSB  = 0;
  localparam int ARTRUST_MSB  = 0;
  localparam int ARSIZE_LSB   = 1;
  localparam int ARSIZE_MSB   = 3;
  localparam int ARPROT_LSB   = 4;
  localparam int ARPROT_MSB   = 6;
  localparam int ARLOCK_LSB   = 7;
  localparam int ARLOCK_MSB   = 7;
  localparam int RSVD_LSB     = 8;
  localparam int RSVD_MSB     = 8;
  localparam int ARLEN_LO_LSB = 9;
  localparam int ARLEN_LO_MSB = 12;
  localparam int ARID_LSB     = 13;
  localparam int ARID_MSB     = 20;
  localparam int ARCACHE_LSB  = 21;
  localparam int ARCACHE_MSB  = 24;
  localparam int ARBURST_LSB  = 25;
  localparam int ARBURST_MSB  = 26;
  localparam int ARADDR_LSB   = 27;
  localparam int ARADDR_MSB   = 66;
  localparam int ARLEN_HI_LSB = 67;
  localparam int ARLEN_HI_MSB = 70;

  // Declared MSB first so the packed bit positions match the localparams above.
  typedef struct packed {
    logic [3:0]  arlen_hi;
    logic [39:0] araddr;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [7:0]  arid;
    logic [3:0]  arlen_lo;
    logic        rsvd;
    logic        arlock;
    logic [2:0]  arprot;
    logic [2:0]  arsize;
    logic        artrust;
  } ar_payload_t;

endpackage

// File: rtl/slot_delay_counter.sv
// Loadable down-counter that holds a FIFO slot back for a programmed number of cycles.
// A load always wins over the decrement; the count saturates at zero.
module slot_delay_counter #(
  parameter int CNT_WIDTH = axi_fifo_pkg::CNT_WIDTH
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_b,
  input  logic                 load_en_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  output logic                 done_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_en_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/axi_ar_delay_slot.sv
// One AR delay-FIFO slot: an opaque payload register plus a release-delay counter.
// No handshake lives here; the parent owns valid, pointers and pop decisions.
module axi_ar_delay_slot #(
  parameter int DATA_WIDTH = axi_fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = axi_fifo_pkg::CNT_WIDTH
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_b,
  input  logic                  create_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  counter_en,
  input  logic [CNT_WIDTH-1:0]  counter_load,
  output logic                  counter_done
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (create_en) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

  // Loads are independent of creates: a slot created without a load stays at zero and is poppable.
  slot_delay_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_delay_cnt (
    .cpu_clk    (cpu_clk),
    .cpu_rst_b  (cpu_rst_b),
    .load_en_i  (counter_en),
    .load_val_i (counter_load),
    .done_o     (counter_done)
  );

endmodule

// File: tb/tb_axi_ar_delay_slot.sv
// Directed bench for axi_ar_delay_slot: reset, capture/hold, delay timing, reload and async reset.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi_ar_delay_slot;
  import axi_fifo_pkg::*;

  localparam int DW = axi_fifo_pkg::DATA_WIDTH;
  localparam int CW = axi_fifo_pkg::CNT_WIDTH;

  // clock / reset
  logic          cpu_clk;
  logic          cpu_rst_b;
  logic          create_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          counter_en;
  logic [CW-1:0] counter_load;
  logic          counter_done;

  int err_cnt;
  int chk_cnt;

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  axi_ar_delay_slot dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst_b    (cpu_rst_b),
    .create_en    (create_en),
    .data_in      (data_in),
    .data_out     (data_out),
    .counter_en   (counter_en),
    .counter_load (counter_load),
    .counter_done (counter_done)
  );

  // scoreboard
  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(negedge cpu_clk);
  endtask

  task automatic load_counter(input logic [CW-1:0] n);
    counter_en   = 1'b1;
    counter_load = n;
  endtask

  logic [DW-1:0] pat_a;
  logic [DW-1:0] pat_b;
  ar_payload_t   pl;

  initial begin
    err_cnt      = 0;
    chk_cnt      = 0;
    cpu_rst_b    = 1'b0;
    create_en    = 1'b0;
    data_in      = '0;
    counter_en   = 1'b0;
    counter_load = '0;
    pat_a        = 71'h5A_0000_1234_5678_9ABC;
    pat_b        = 71'h21_FFFF_0000_DEAD_BEEF;

    // reset state
    #3;
    check_val("rst_data", data_out, '0);
    check_val("rst_done", counter_done, 1'b1);
    next_cycle();
    #2 cpu_rst_b = 1'b1;
    next_cycle();
    next_cycle();
    check_val("post_rst_data", data_out, '0);
    check_val("post_rst_done", counter_done, 1'b1);

    // capture then hold
    create_en = 1'b1;
    data_in   = pat_a;
    next_cycle();
    check_val("cap_data", data_out, pat_a);
    check_val("cap_no_load_done", counter_done, 1'b1);
    create_en = 1'b0;
    data_in   = pat_b;
    next_cycle();
    check_val("hold_data_1", data_out, pat_a);
    next_cycle();
    check_val("hold_data_2", data_out, pat_a);

    // delay of 3: done low for exactly three sampled cycles
    load_counter(32'd3);
    next_cycle();
    counter_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("d3_low_%0d", i), counter_done, 1'b0);
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("d3_high_%0d", i), counter_done, 1'b1);
      next_cycle();
    end

    // zero load never drops done
    load_counter(32'd0);
    next_cycle();
    counter_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("zero_%0d", i), counter_done, 1'b1);
      next_cycle();
    end

    // reload 10, then 2 after four cycles
    load_counter(32'd10);
    next_cycle();
    counter_en = 1'b0;
    check_val("rl_low_a", counter_done, 1'b0);
    repeat (3) next_cycle();
    check_val("rl_low_b", counter_done, 1'b0);
    load_counter(32'd2);
    next_cycle();
    counter_en = 1'b0;
    check_val("rl2_low_0", counter_done, 1'b0);
    next_cycle();
    check_val("rl2_low_1", counter_done, 1'b0);
    next_cycle();
    check_val("rl2_high", counter_done, 1'b1);
    next_cycle();
    check_val("rl2_stay", counter_done, 1'b1);

    // structured payload lands at its field positions
    pl          = '0;
    pl.araddr   = 40'hAB_CDEF_0123;
    pl.arid     = 8'h5C;
    pl.arlen_hi = 4'h9;
    pl.arsize   = 3'h3;
    create_en   = 1'b1;
    data_in     = pl;
    next_cycle();
    create_en   = 1'b0;
    check_val("fld_araddr", data_out[ARADDR_MSB:ARADDR_LSB], 40'hAB_CDEF_0123);
    check_val("fld_arid", data_out[ARID_MSB:ARID_LSB], 8'h5C);
    check_val("fld_arlen_hi", data_out[ARLEN_HI_MSB:ARLEN_HI_LSB], 4'h9);
    check_val("fld_arsize", data_out[ARSIZE_MSB:ARSIZE_LSB], 3'h3);

    // async reset in the middle of a 100-cycle countdown
    load_counter(32'd100);
    next_cycle();
    counter_en = 1'b0;
    next_cycle();
    next_cycle();
    check_val("ar_pre_done", counter_done, 1'b0);
    check_val("ar_pre_data", data_out, 71'(pl));
    #2 cpu_rst_b = 1'b0;
    #1;
    check_val("ar_done_now", counter_done, 1'b1);
    check_val("ar_data_now", data_out, '0);
    #1 cpu_rst_b = 1'b1;
    next_cycle();
    check_val("ar_after_done", counter_done, 1'b1);
    check_val("ar_after_data", data_out, '0);

    // final report
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axi_ar_delay_slot.md
# axi_ar_delay_slot

One storage slot of the AXI read-address (AR) delay FIFO in the C908 test harness. It has two parts:
- a 71-bit payload register that captures one packed AR request;
- a 32-bit down-counter that holds the request back for a programmable number of cycles.

The parent FIFO instantiates eight slots, one per one-hot pointer position. It pops the slot under its pop pointer once that slot is valid and `counter_done` is high.

## Interface
Parameters:
- `DATA_WIDTH`, default 71: packed AR payload width.
- `CNT_WIDTH`, default 32: delay counter width.

Ports:
- `cpu_clk`, in, 1: clock; all state updates on the rising edge.
- `cpu_rst_b`, in, 1: reset, asynchronous, active-low.
- `create_en`, in, 1: capture `data_in` into the slot this cycle.
- `data_in`, in, `DATA_WIDTH`: packed AR request.
- `data_out`, out, `DATA_WIDTH`: stored payload, driven directly from the register.
- `counter_en`, in, 1: load `counter_load` into the delay counter.
- `counter_load`, in, `CNT_WIDTH`: delay in cycles.
- `counter_done`, out, 1: high when the counter equals 0.

## Operation
- Payload register:
  - On reset, cleared to all zeros.
  - On an edge with `create_en`=1, loads `data_in`.
  - Otherwise holds its value; no other clear path.
  - `data_out` is the register output with no bypass.
- Delay counter:
  - On reset, the count is 0, so `counter_done` is 1 out of reset.
  - On an edge with `counter_en`=1, count <= `counter_load`. Load takes priority over decrement, so a reload during a countdown restarts it.
  - Otherwise, if count != 0, count <= count − 1. At 0 the count holds; it never wraps.
  - `counter_done` = (count == 0), combinational from the count register.
- `counter_en` and `create_en` are independent. The parent asserts `counter_en` only for a subset of creates (cacheable SRAM hits). Slots created without a load keep count 0 and are immediately poppable.
- Payload layout, used by the parent only; this block treats the payload as opaque:
  - [0] artrust (written 0)
  - [3:1] arsize
  - [6:4] arprot
  - [7] arlock
  - [8] reserved (0)
  - [12:9] arlen[3:0]
  - [20:13] arid
  - [24:21] arcache
  - [26:25] arburst
  - [66:27] araddr[39:0]
  - [70:67] arlen[7:4]

## Timing
- Payload latency: 1 cycle. Data driven while `create_en` is high at edge k appears on `data_out` after edge k.
- Counter load of N at edge k:
  - `counter_done` goes low after edge k when N > 0.
  - It returns high after edge k+N, i.e. N cycles of done=0.
  - N = 0 keeps done high continuously.
- Reset asserted mid-countdown or mid-hold clears both registers immediately (asynchronously), so `counter_done`=1 and `data_out`=0.
- No handshake inside the block. The parent owns the valid, pointer and ready logic.

## Structure
- Shared package (`axi_fifo_pkg`):
  - `DATA_WIDTH` and `CNT_WIDTH` constants;
  - payload field LSB/MSB localparams for the layout above;
  - a packed AR payload typedef.
- One sub-module is natural: `slot_delay_counter`, holding the load/decrement/done logic. The payload register stays inline in the top.

## Test plan
- Reset check: assert `cpu_rst_b`=0 → `data_out`=71'h0 and `counter_done`=1; deassert → values hold with no inputs active.
- Capture/hold: `create_en`=1 with `data_in`=71'h5A_0000_1234_5678_9ABC for one cycle, then `data_in` changes with `create_en`=0 → `data_out` holds the first value.
- Delay of 3: pulse `counter_en` with `counter_load`=3 → `counter_done`=0 for exactly 3 cycles, then 1 and stays 1.
- Zero load: `counter_load`=0 with `counter_en`=1 → `counter_done` never drops.
- Reload mid-count: load 10, and after 4 cycles load 2 → done returns high 2 cycles after the second load.
- Async reset: reset pulsed between clock edges during a countdown of 100 → `counter_done`=1 and `data_out`=0 immediately, before the next edge.
